logo_scroll_ctrl: RTL and testbench
===================================

Name: logo_scroll_ctrl

Overview:
- Frame-synchronous sequencer for the VGA logo painters; generates the horizontal offset `delt` and the painter enable shared by all letter painters.
- Moves the logo back and forth across the screen (ping-pong) with a programmable frame divider and end-stop dwell.
- Updates only on the frame-start strobe, so a frame never tears mid-scan.
- Sits between the VGA sync generator and the logo painter instances.

Parameters:
- MAX_DELT, 11'd200, largest offset value; the right end-stop.
- STEP, 11'd2, pixels moved per advance.
- HOLD_FRAMES, 8'd30, frames spent dwelling at each end-stop.
- DIV_W, 4, width of the frame-divider compare value.

Ports:
- clk, input, 1, pixel/system clock.
- rst, input, 1, asynchronous reset, active-low.
- frame_start, input, 1, one-cycle strobe at the start of vertical blank.
- run, input, 1, 1 = animate; 0 = freeze at the current offset.
- show, input, 1, logo visibility request.
- div, input, DIV_W, advance every div+1 frames.
- delt, output, 11, registered offset to the painters.
- logo_en, output, 1, registered painter enable.
- dir_left, output, 1, 1 while moving or dwelling toward offset 0.
- at_stop, output, 1, 1 while in either HOLD state.

Behaviour:
- Reset (rst=0, async): state=IDLE, delt=0, logo_en=0, dir_left=0, at_stop=0, frame counter=0, hold counter=0.
- All state changes occur only on a clk edge where frame_start=1. All other cycles hold every register.
- logo_en = show, sampled on frame_start, 1-frame latency. The internal movement logic ignores show.
- States:
  - IDLE: on frame_start with run=1 → RIGHT; frame counter cleared.
  - RIGHT: on each frame_start with run=1:
    - If frame counter == div: counter clears and delt advances.
    - Else: counter increments.
    - Advance rule: delt = min(delt+STEP, MAX_DELT), using a 12-bit intermediate to avoid wrap.
    - When the new delt == MAX_DELT: go to HOLD_R, hold counter=0, at_stop=1.
  - HOLD_R: each frame_start increments the hold counter. At HOLD_FRAMES-1 → LEFT, dir_left=1, at_stop=0.
  - LEFT: mirror of RIGHT.
    - Advance rule: delt = (delt<STEP) ? 0 : delt-STEP.
    - Reaching 0 → HOLD_L.
  - HOLD_L: mirror of HOLD_R; on expiry → RIGHT, dir_left=0.
- run=0 in any state: counters and delt frozen, state retained. Resuming continues exactly where it stopped.
- run=0 in IDLE: stay in IDLE.
- div=0: advance every frame.
- A change of div takes effect at the next compare. If the counter is already > div, the compare uses >=, so the advance happens on the next frame.
- HOLD_FRAMES=0: treated as 1 (dwell one frame).
- frame_start asserted on consecutive cycles: each strobe is a frame; no filtering.
- Reset mid-scroll: immediate return to reset values; the next run restarts from delt=0 moving right.
- Invariant: delt never exceeds MAX_DELT.

Decomposition:
- Shared package `logo_pkg`:
  - state encoding (IDLE, RIGHT, HOLD_R, LEFT, HOLD_L as 3-bit localparams);
  - screen constants LOGO_BASE_X=500 and LOGO_BASE_Y=550, which the painters use.
- One natural sub-module: `frame_divider`, the frame-strobe counter with a >= compare that outputs a one-cycle `advance` pulse.

Test Plan:
- Reset then run=1, div=0, STEP=2, MAX_DELT=200: delt sequence is 2, 4, … on successive frame_start strobes. Reaches 200 after 100 frames, at which point at_stop=1.
- Continue from the previous scenario, HOLD_FRAMES=30: delt stays at 200 for 30 frames. dir_left becomes 1 on the 30th frame; delt=198 on the next advance.
- div=3: delt changes once every 4 frame_start strobes. Toggling frame_start-free cycles in between changes nothing.
- MAX_DELT=201, STEP=2: delt goes 198 → 200 → 201 (clamped). Moving left from 1 with STEP=2 gives 0, with no underflow.
- run=0 for 10 frames mid-scroll at delt=120: delt stays 120 and the state is held. On run=1, movement resumes in the same direction. show toggles logo_en one frame later regardless of run.
- Assert rst=0 asynchronously mid-frame with delt=150 and dir_left=1: all outputs are 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/logo_pkg.sv
// -----------------------------------------------------------------------------
// logo_pkg
// Shared definitions for the VGA logo path: scroll FSM state encoding, the
// screen anchor the letter painters add the scroll offset to, and a helper
// that turns a dwell length into the last hold-counter value.
// -----------------------------------------------------------------------------
package logo_pkg;

    // Scroll sequencer states (plain 3-bit constants so older painter code
    // that compares against raw values keeps working).
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RIGHT  = 3'd1;
    localparam logic [2:0] ST_HOLD_R = 3'd2;
    localparam logic [2:0] ST_LEFT   = 3'd3;
    localparam logic [2:0] ST_HOLD_L = 3'd4;

    // Top-left anchor of the logo; painters draw at (LOGO_BASE_X + delt, LOGO_BASE_Y).
    localparam logic [10:0] LOGO_BASE_X = 11'd500;
    localparam logic [10:0] LOGO_BASE_Y = 11'd550;

    // Width of the scroll offset bus.
    localparam int DELT_W = 11;

    // Last hold-counter value before leaving an end-stop. A dwell of zero
    // frames is not meaningful, so it collapses to a single-frame dwell.
    function automatic logic [7:0] hold_last(input logic [7:0] frames);
        return (frames == 8'd0) ? 8'd0 : frames - 8'd1;
    endfunction

endpackage

// File: rtl/frame_divider.sv
// -----------------------------------------------------------------------------
// frame_divider
// Counts qualified frame strobes and pulses `advance_o` on every (div_i+1)-th
// one. The compare is >= so that lowering div_i below the current count makes
// the very next strobe advance instead of waiting for the counter to wrap.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous reset, active-low
//   clear_i   in   force the count back to zero (used outside the moving states)
//   en_i      in   qualified frame strobe (frame_start & run & moving)
//   div_i     in   advance every div_i+1 strobes
//   advance_o out  one-cycle pulse, combinational from en_i and the count
// -----------------------------------------------------------------------------
module frame_divider #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             advance_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign advance_o = en_i && (cnt_q >= div_i);

    // NOTE: every always_comb output gets a default on its first line, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = advance_o ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/logo_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// logo_scroll_ctrl
// Frame-synchronous ping-pong sequencer for the logo painters. The offset
// `delt` walks from 0 to MAX_DELT in STEP increments, dwells HOLD_FRAMES
// frames, walks back to 0, dwells again, and repeats. Every register moves
// only on a frame_start cycle, so the painters never see a change mid-scan.
//
// Ports:
//   clk          in   pixel/system clock
//   rst          in   asynchronous reset, active-low
//   frame_start  in   one-cycle strobe at the start of vertical blank
//   run          in   1 = animate, 0 = freeze (state, counters, delt held)
//   show         in   logo visibility request, forwarded to logo_en per frame
//   div          in   advance every div+1 frames
//   delt         out  registered horizontal offset, never above MAX_DELT
//   logo_en      out  registered painter enable
//   dir_left     out  1 while moving or dwelling toward offset 0
//   at_stop      out  1 while dwelling at either end-stop
// -----------------------------------------------------------------------------
module logo_scroll_ctrl
    import logo_pkg::*;
#(
    parameter logic [10:0] MAX_DELT    = 11'd200,
    parameter logic [10:0] STEP        = 11'd2,
    parameter logic [7:0]  HOLD_FRAMES = 8'd30,
    parameter int          DIV_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             run,
    input  logic             show,
    input  logic [DIV_W-1:0] div,
    output logic [10:0]      delt,
    output logic             logo_en,
    output logic             dir_left,
    output logic             at_stop
);

    localparam logic [7:0] HOLD_LAST = hold_last(HOLD_FRAMES);

    logic [2:0]        state_q, state_d;
    logic [DELT_W-1:0] delt_q,  delt_d;
    logic [7:0]        hold_q,  hold_d;
    logic              dir_q,   dir_d;
    logic              stop_q,  stop_d;
    logic              en_q;

    logic              tick;
    logic              moving;
    logic              advance;
    logic [DELT_W:0]   sum_right;
    logic [DELT_W-1:0] next_right;
    logic [DELT_W-1:0] next_left;

    // Movement only reacts to frames seen while running; show is independent.
    assign tick   = frame_start && run;
    assign moving = (state_q == ST_RIGHT) || (state_q == ST_LEFT);

    // The divider only counts in the moving states and is parked at zero
    // otherwise, so each sweep starts with a full div+1 frame interval.
    frame_divider #(
        .DIV_W (DIV_W)
    ) u_frame_divider (
        .clk       (clk),
        .rst_n     (rst),
        .clear_i   (tick && !moving),
        .en_i      (tick && moving),
        .div_i     (div),
        .advance_o (advance)
    );

    // One extra bit on the rightward sum keeps a large STEP from wrapping
    // past the top of the 11-bit range before the clamp sees it.
    assign sum_right  = {1'b0, delt_q} + {1'b0, STEP};
    assign next_right = (sum_right >= {1'b0, MAX_DELT}) ? MAX_DELT : sum_right[DELT_W-1:0];
    assign next_left  = (delt_q < STEP) ? '0 : delt_q - STEP;

    always_comb begin
        state_d = state_q;
        delt_d  = delt_q;
        hold_d  = hold_q;
        dir_d   = dir_q;
        stop_d  = stop_q;

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RIGHT;
                end

                ST_RIGHT: begin
                    if (advance) begin
                        delt_d = next_right;
                        if (next_right == MAX_DELT) begin
                            state_d = ST_HOLD_R;
                            hold_d  = '0;
                            stop_d  = 1'b1;
                        end
                    end
                end

                ST_HOLD_R: begin
                    if (hold_q >= HOLD_LAST) begin
                        state_d = ST_LEFT;
                        hold_d  = '0;
                        dir_d   = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end

                ST_LEFT: begin
                    if (advance) begin
                        delt_d = next_left;
                        if (next_left == '0) begin
                            state_d = ST_HOLD_L;
                            hold_d  = '0;
                            stop_d  = 1'b1;
                        end
                    end
                end

                ST_HOLD_L: begin
                    if (hold_q >= HOLD_LAST) begin
                        state_d = ST_RIGHT;
                        hold_d  = '0;
                        dir_d   = 1'b0;
                        stop_d  = 1'b0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            delt_q  <= '0;
            hold_q  <= '0;
            dir_q   <= 1'b0;
            stop_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            delt_q  <= delt_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            stop_q  <= stop_d;
            // Visibility follows show once per frame, even while frozen.
            if (frame_start) begin
                en_q <= show;
            end
        end
    end

    assign delt     = delt_q;
    assign logo_en  = en_q;
    assign dir_left = dir_q;
    assign at_stop  = stop_q;

endmodule

// File: tb/tb_logo_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_logo_scroll_ctrl
// Two instances: the default build (MAX_DELT=200, HOLD_FRAMES=30) and a build
// with an odd end-stop (MAX_DELT=201) and HOLD_FRAMES=0. A behavioural model
// predicts the outputs for every driven strobe; predictions are queued when
// the strobe is driven and compared once the clock edge has taken effect.
// -----------------------------------------------------------------------------
module tb_logo_scroll_ctrl;

    typedef struct {
        int st;     // 0 idle, 1 right, 2 hold right, 3 left, 4 hold left
        int delt;
        int cnt;
        int hold;
        bit en;
        bit dir;
        bit stop;
    } model_t;

    typedef struct packed {
        logic [10:0] delt;
        logic        en;
        logic        dir;
        logic        stop;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs1, run1, show1;
    logic [3:0]  div1;
    logic [10:0] delt1;
    logic        en1, dir1, stop1;
    logic        fs2, run2, show2;
    logic [3:0]  div2;
    logic [10:0] delt2;
    logic        en2, dir2, stop2;

    int checks   = 0;
    int failures = 0;

    model_t m1, m2;
    out_t   q1[$];
    out_t   q2[$];

    always #5 clk = ~clk;

    logo_scroll_ctrl u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .frame_start (fs1),
        .run         (run1),
        .show        (show1),
        .div         (div1),
        .delt        (delt1),
        .logo_en     (en1),
        .dir_left    (dir1),
        .at_stop     (stop1)
    );

    logo_scroll_ctrl #(
        .MAX_DELT    (11'd201),
        .STEP        (11'd2),
        .HOLD_FRAMES (8'd0),
        .DIV_W       (4)
    ) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .frame_start (fs2),
        .run         (run2),
        .show        (show2),
        .div         (div2),
        .delt        (delt2),
        .logo_en     (en2),
        .dir_left    (dir2),
        .at_stop     (stop2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one frame_start strobe.
    function automatic model_t mstep(input model_t m, input int max_d, input int stp,
                                     input int hold_n, input bit run_b, input bit show_b,
                                     input int div_v);
        model_t r = m;
        int dwell = (hold_n < 1) ? 1 : hold_n;
        r.en = show_b;
        if (!run_b) return r;
        case (m.st)
            0: begin
                r.st  = 1;
                r.cnt = 0;
            end
            1, 3: begin
                if (m.cnt >= div_v) begin
                    r.cnt = 0;
                    if (m.st == 1) begin
                        r.delt = (m.delt + stp > max_d) ? max_d : m.delt + stp;
                        if (r.delt == max_d) begin r.st = 2; r.hold = 0; r.stop = 1; end
                    end else begin
                        r.delt = (m.delt < stp) ? 0 : m.delt - stp;
                        if (r.delt == 0) begin r.st = 4; r.hold = 0; r.stop = 1; end
                    end
                end else begin
                    r.cnt = m.cnt + 1;
                end
            end
            default: begin
                if (m.hold + 1 >= dwell) begin
                    r.st   = (m.st == 2) ? 3 : 1;
                    r.dir  = (m.st == 2);
                    r.stop = 0;
                    r.hold = 0;
                    r.cnt  = 0;
                end else begin
                    r.hold = m.hold + 1;
                end
            end
        endcase
        return r;
    endfunction

    function automatic out_t pack(input model_t m);
        out_t o;
        o.delt = m.delt[10:0];
        o.en   = m.en;
        o.dir  = m.dir;
        o.stop = m.stop;
        return o;
    endfunction

    task automatic compare(input string tag, input out_t obs, input out_t exp);
        check({tag, ".delt"},     32'(obs.delt), 32'(exp.delt));
        check({tag, ".logo_en"},  32'(obs.en),   32'(exp.en));
        check({tag, ".dir_left"}, 32'(obs.dir),  32'(exp.dir));
        check({tag, ".at_stop"},  32'(obs.stop), 32'(exp.stop));
    endtask

    task automatic pop1(input string tag);
        out_t o;
        o.delt = delt1; o.en = en1; o.dir = dir1; o.stop = stop1;
        if (q1.size() == 0) check({tag, ".queue_empty"}, 32'd1, 32'd0);
        else compare(tag, o, q1.pop_front());
    endtask

    task automatic pop2(input string tag);
        out_t o;
        o.delt = delt2; o.en = en2; o.dir = dir2; o.stop = stop2;
        if (q2.size() == 0) check({tag, ".queue_empty"}, 32'd1, 32'd0);
        else compare(tag, o, q2.pop_front());
    endtask

    // Back-to-back calls produce strobes on consecutive clock cycles.
    task automatic strobe1(input string tag);
        @(negedge clk);
        fs1 = 1'b1;
        m1 = mstep(m1, 200, 2, 30, run1, show1, int'(div1));
        q1.push_back(pack(m1));
        @(posedge clk);
        #1 fs1 = 1'b0;
        pop1(tag);
    endtask

    task automatic strobe2(input string tag);
        @(negedge clk);
        fs2 = 1'b1;
        m2 = mstep(m2, 201, 2, 0, run2, show2, int'(div2));
        q2.push_back(pack(m2));
        @(posedge clk);
        #1 fs2 = 1'b0;
        pop2(tag);
    endtask

    // Cycles without frame_start must leave every output alone.
    task automatic idle1(input int n, input string tag);
        q1.push_back(pack(m1));
        repeat (n) @(posedge clk);
        #1 pop1(tag);
    endtask

    initial begin
        rst = 1'b0;
        fs1 = 1'b0; run1 = 1'b0; show1 = 1'b0; div1 = 4'd0;
        fs2 = 1'b0; run2 = 1'b0; show2 = 1'b0; div2 = 4'd0;
        m1 = '{default: 0};
        m2 = '{default: 0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst.delt",     32'(delt1), 32'd0);
        check("rst.logo_en",  32'(en1),   32'd0);
        check("rst.dir_left", 32'(dir1),  32'd0);
        check("rst.at_stop",  32'(stop1), 32'd0);
        check("rst2.delt",    32'(delt2), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Sweep right at div=0: first strobe leaves IDLE, then +2 per frame.
        run1 = 1'b1; show1 = 1'b1; div1 = 4'd0;
        strobe1("idle_to_right");
        check("first_frame.delt", 32'(delt1), 32'd0);
        for (int i = 0; i < 100; i++) strobe1("sweep_right");
        check("right_end.delt",    32'(delt1), 32'd200);
        check("right_end.at_stop", 32'(stop1), 32'd1);

        // Dwell 30 frames at the right end-stop, then head left.
        for (int i = 0; i < 29; i++) strobe1("hold_right");
        check("hold_29.dir_left", 32'(dir1), 32'd0);
        strobe1("hold_right_last");
        check("hold_30.dir_left", 32'(dir1),  32'd1);
        check("hold_30.at_stop",  32'(stop1), 32'd0);
        check("hold_30.delt",     32'(delt1), 32'd200);
        strobe1("left_first");
        check("left_first.delt", 32'(delt1), 32'd198);
        for (int i = 0; i < 24; i++) strobe1("sweep_left");
        check("left_150.delt", 32'(delt1), 32'd150);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_rst.delt",     32'(delt1), 32'd0);
        check("async_rst.logo_en",  32'(en1),   32'd0);
        check("async_rst.dir_left", 32'(dir1),  32'd0);
        check("async_rst.at_stop",  32'(stop1), 32'd0);
        m1 = '{default: 0};
        m2 = '{default: 0};
        @(negedge clk);
        rst = 1'b1;

        // div=3 with idle gaps: one advance per four strobes, restart from 0.
        div1 = 4'd3;
        strobe1("restart");
        for (int i = 0; i < 8; i++) begin
            strobe1("div3");
            idle1(2, "div3_gap");
        end
        check("div3.delt", 32'(delt1), 32'd4);
        for (int i = 0; i < 3; i++) strobe1("div3_count");
        check("div3_count.delt", 32'(delt1), 32'd4);
        // Count is now above the new divider: advance on the next strobe.
        div1 = 4'd1;
        strobe1("div_lowered");
        check("div_lowered.delt", 32'(delt1), 32'd6);
        div1 = 4'd0;
        for (int i = 0; i < 57; i++) strobe1("to_120");
        check("to_120.delt", 32'(delt1), 32'd120);

        // Freeze for 10 frames while toggling show.
        run1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            show1 = i[0];
            strobe1("frozen");
        end
        check("frozen.delt",    32'(delt1), 32'd120);
        check("frozen.logo_en", 32'(en1),   32'd1);
        idle1(3, "frozen_gap");
        run1 = 1'b1; show1 = 1'b0;
        strobe1("resume");
        check("resume.delt",     32'(delt1), 32'd122);
        check("resume.dir_left", 32'(dir1),  32'd0);
        check("resume.logo_en",  32'(en1),   32'd0);

        // Odd end-stop clamps to 201; HOLD_FRAMES=0 dwells one frame.
        run2 = 1'b1; show2 = 1'b1; div2 = 4'd0;
        strobe2("b_idle_to_right");
        for (int i = 0; i < 100; i++) strobe2("b_sweep_right");
        check("b_200.delt", 32'(delt2), 32'd200);
        strobe2("b_clamp");
        check("b_clamp.delt",    32'(delt2), 32'd201);
        check("b_clamp.at_stop", 32'(stop2), 32'd1);
        strobe2("b_hold");
        check("b_hold.dir_left", 32'(dir2), 32'd1);
        for (int i = 0; i < 100; i++) strobe2("b_sweep_left");
        check("b_at_1.delt", 32'(delt2), 32'd1);
        strobe2("b_underflow");
        check("b_underflow.delt",    32'(delt2), 32'd0);
        check("b_underflow.at_stop", 32'(stop2), 32'd1);
        strobe2("b_hold_left");
        check("b_hold_left.dir_left", 32'(dir2), 32'd0);
        strobe2("b_right_again");
        check("b_right_again.delt", 32'(delt2), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
